mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the data-memory side of the single-cycle ARM core, acting as a bus responder to the core's data-port requests.
- Decodes the core's data address (ALUResult), accepts stores (MemWrite/WriteData), and returns load data combinationally on ReadData, so single-cycle LDR timing is preserved.
- Written bytes enter a small FIFO, then shift out serially as 8N1 frames on txd.
- The top-level read mux selects ReadData when Hit=1, otherwise data-memory ReadData.

Parameters:
- BASE_ADDR, 32'h0000_0100: word-aligned base of the 3-register window.
- DEPTH, 4: FIFO entries; power of 2, 2..16.
- DEFAULT_DIV, 16: reset value of BAUDDIV, in clk cycles per bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  core store strobe.
- ALUResult  input  32  core data address; bits [1:0] ignored.
- WriteData  input  32  core store data.
- ReadData  output  32  combinational load data; 0 when not Hit.
- Hit  output  1  combinational; 1 when ALUResult[31:2] addresses BASE_ADDR+0, +4 or +8.
- txd  output  1  registered serial output; idle high.

Behaviour:
- Register map (word offsets):
  - +0 TXDATA: write pushes WriteData[7:0]; reads return 0.
  - +4 STATUS: read {24'b0, count[3:0], ovf, empty, full, busy} = bits 7:4, 3, 2, 1, 0. Writing with WriteData[3]=1 clears ovf; other bits are read-only.
  - +8 BAUDDIV: read/write, bits [15:0]; upper bits read 0. A written value of 0 is stored as 1.
- Out-of-window stores are ignored. ReadData is driven purely from the address and current state, with no latency.
- Reset (takes precedence over every other event, including mid-frame):
  - txd=1, state=IDLE, FIFO emptied (count=0), ovf=0, BAUDDIV=DEFAULT_DIV.
  - Shift register and bit/baud counters cleared.
- Push rule: a TXDATA store is accepted iff count<DEPTH before the edge. A store while full is dropped and sets ovf=1 (sticky). Fullness is evaluated pre-edge, so a store while full is dropped even if a pop occurs on the same edge.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and data ordering is preserved.
- FIFO pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. On an edge with count>0: pop head into shift register, latch div_act=BAUDDIV, clear baud counter, go to START (txd=0 from that edge).
  - START: holds div_act cycles, then goes to DATA with bit index 0.
  - DATA: txd = shift[idx], LSB first. Each bit holds div_act cycles. After idx=7, go to STOP.
  - STOP: txd=1 for div_act cycles. At the end, if count>0, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length is exactly 10*div_act cycles.
- A BAUDDIV write mid-frame takes effect only at the next frame start.
- busy=1 in every state except IDLE. empty=(count==0); full=(count==DEPTH).
- The baud counter counts 0..div_act-1; wrap-around triggers the bit advance.

Test Plan:
- Reset, then read all registers:
  - STATUS reads 32'h0000_0004 (empty=1); BAUDDIV reads 16; txd=1.
  - An address outside the window returns ReadData=0 and Hit=0.
- BAUDDIV=4, store 8'hA5 to TXDATA:
  - txd goes low 1 cycle after the store edge.
  - txd then shows bits 1,0,1,0,0,1,0,1, each held 4 cycles, followed by 4 high cycles; total frame is 40 cycles.
  - busy returns to 0 afterwards.
- BAUDDIV=2, DEPTH=4, 6 back-to-back stores 8'h01..8'h06:
  - The first store is popped immediately; stores 2-5 fill the FIFO; the 6th is dropped.
  - STATUS shows ovf=1, full=1, count=4.
  - Frames 01,02,03,04,05 are emitted with no idle gap between stop and start bits.
  - Writing STATUS with bit3 set clears ovf.
- BAUDDIV=3 and a frame in flight, write BAUDDIV=5 mid-frame:
  - The current frame keeps 3-cycle bits.
  - The next queued frame uses 5-cycle bits.
  - Writing BAUDDIV=0 reads back 1.
- Reset asserted mid-DATA with 2 bytes queued:
  - txd=1 on the next edge; STATUS returns to 32'h4.
  - No further frames are emitted.
- FIFO full while a pop occurs in the same cycle as a TXDATA store:
  - The store is dropped and ovf=1.
  - count decrements by 1.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV window, byte FIFO, serial shifter.
// ReadData and Hit are combinational so a single-cycle LDR sees the value in the same cycle.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        txd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [29:0] W_TX = BASE_ADDR[31:2];
    localparam logic [29:0] W_ST = W_TX + 30'd1;
    localparam logic [29:0] W_BD = W_TX + 30'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   div_act_q, div_act_d;
    logic [15:0]   bauddiv_q, bauddiv_d;
    logic          ovf_q, ovf_d;
    logic          txd_q, txd_d;

    logic sel_tx, sel_st, sel_bd;
    logic empty, full, busy, tick, push_ok, pop;
    logic [4:0] count_ext;
    logic unused_bits;

    assign unused_bits = ^{ALUResult[1:0], WriteData[31:16], count_ext[4]};
    assign txd = txd_q;

    always_comb begin
        sel_tx    = (ALUResult[31:2] == W_TX);
        sel_st    = (ALUResult[31:2] == W_ST);
        sel_bd    = (ALUResult[31:2] == W_BD);
        Hit       = sel_tx | sel_st | sel_bd;
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        busy      = (state_q != S_IDLE);
        count_ext = 5'(count_q);
        ReadData  = '0;
        if (sel_st) ReadData = {24'b0, count_ext[3:0], ovf_q, empty, full, busy};
        if (sel_bd) ReadData = {16'b0, bauddiv_q};
    end

    // Push handshake: valid = TXDATA store, ready = !full sampled before the edge;
    // valid without ready drops the byte and raises the sticky ovf flag.
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        baud_d    = baud_q;
        div_act_d = div_act_q;
        bauddiv_d = bauddiv_q;
        ovf_d     = ovf_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        tick      = (baud_q == div_act_q - 16'd1);
        push_ok   = MemWrite && sel_tx && !full;

        if (MemWrite && sel_tx && full) ovf_d = 1'b1;
        if (MemWrite && sel_st && WriteData[3]) ovf_d = 1'b0;
        if (MemWrite && sel_bd) bauddiv_d = (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    baud_d  = 16'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_d = 16'd0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                if (tick) begin
                    baud_d = 16'd0;
                    if (!empty) pop = 1'b1;
                    else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase

        // A new frame latches the divisor so mid-frame BAUDDIV writes wait for the next frame.
        if (pop) begin
            shift_d   = mem_q[rd_ptr_q];
            div_act_d = bauddiv_q;
            baud_d    = 16'd0;
            idx_d     = 3'd0;
            state_d   = S_START;
            txd_d     = 1'b0;
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = WriteData[7:0];
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            baud_q    <= '0;
            div_act_q <= '0;
            bauddiv_q <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            baud_q    <= baud_d;
            div_act_q <= div_act_d;
            bauddiv_q <= bauddiv_d;
            ovf_q     <= ovf_d;
            txd_q     <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, compared every cycle
// against a frame-level model (byte queue, frame timer, bit = t / div).
module tb_mmio_uart_tx;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_BD = BASE + 32'd8;
  localparam logic [31:0] A_OUT = 32'h0000_0200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_write = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic hit;
  logic txd;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .MemWrite(mem_write), .ALUResult(alu_result),
    .WriteData(write_data), .ReadData(read_data), .Hit(hit), .txd(txd)
  );

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] exp_q[$];
  bit m_valid = 0;
  bit m_active;
  int m_t;
  int m_div;
  logic [7:0] m_byte;
  logic [15:0] m_baud;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / m_div;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int n = exp_q.size();
    return {24'b0, 4'(n), m_ovf, (n == 0), (n == DEPTH), m_active};
  endfunction

  function automatic void model_step(input logic rst, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wd);
    int n;
    bit frame_end, do_pop, do_push;
    logic [15:0] div_pre;
    if (rst) begin
      exp_q.delete();
      m_active = 0; m_t = 0; m_div = 1; m_byte = '0;
      m_baud = 16'd16; m_ovf = 0; m_valid = 1;
      return;
    end
    n = exp_q.size();
    frame_end = m_active && (m_t == 10 * m_div - 1);
    do_pop = (n > 0) && (!m_active || frame_end);
    div_pre = m_baud;
    do_push = 0;
    if (we && addr[31:2] == A_TX[31:2]) begin
      if (n < DEPTH) do_push = 1;
      else m_ovf = 1;
    end
    if (we && addr[31:2] == A_ST[31:2] && wd[3]) m_ovf = 0;
    if (we && addr[31:2] == A_BD[31:2]) m_baud = (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
    if (do_pop) begin
      m_byte = exp_q.pop_front();
      m_active = 1; m_t = 0; m_div = int'(div_pre);
    end else if (m_active) begin
      if (frame_end) m_active = 0;
      else m_t++;
    end
    if (do_push) exp_q.push_back(wd[7:0]);
  endfunction

  task automatic check_read(input logic [31:0] addr);
    logic [31:0] er;
    logic eh;
    er = '0; eh = 1'b0;
    if (addr[31:2] == A_TX[31:2]) eh = 1'b1;
    if (addr[31:2] == A_ST[31:2]) begin eh = 1'b1; er = exp_status(); end
    if (addr[31:2] == A_BD[31:2]) begin eh = 1'b1; er = {16'b0, m_baud}; end
    check("hit", {31'b0, hit}, {31'b0, eh});
    check("rdata", read_data, er);
  endtask

  // one bus cycle: drive, check combinational read, clock, advance model, check txd
  task automatic cyc(input logic rst, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    reset = rst; mem_write = we; alu_result = addr; write_data = wd;
    #1;
    if (m_valid && !rst) check_read(addr);
    @(posedge clk);
    model_step(rst, we, addr, wd);
    #1;
    check("txd", {31'b0, txd}, {31'b0, exp_txd()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, A_ST, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    cyc(1'b0, 1'b1, addr, wd);
  endtask

  task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    reset = 1'b0; mem_write = 1'b0; alu_result = addr; write_data = '0;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    int found;
    int op;
    logic [31:0] ra;

    // reset and register readback
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, A_OUT, 32'd0);
    peek("rst_status", A_ST, 32'h0000_0004);
    peek("rst_bauddiv", A_BD, 32'h0000_0010);
    peek("rst_txdata", A_TX, 32'h0000_0000);
    peek("outside_rdata", A_OUT, 32'h0000_0000);
    check("outside_hit", {31'b0, hit}, 32'd0);
    check("rst_txd", {31'b0, txd}, 32'd1);
    idle(2);

    // single frame at div 4
    wr(A_BD, 32'd4);
    wr(A_TX, 32'h0000_00A5);
    idle(45);
    peek("a5_done_status", A_ST, 32'h0000_0004);

    // overflow on back-to-back stores at div 2
    wr(A_BD, 32'd2);
    for (int i = 1; i <= 6; i++) wr(A_TX, 32'(i));
    peek("ovf_status", A_ST, 32'h0000_004B);
    idle(110);
    wr(A_ST, 32'h0000_0008);
    peek("ovf_cleared", A_ST, 32'h0000_0004);

    // BAUDDIV change mid-frame
    wr(A_BD, 32'd3);
    wr(A_TX, 32'h0000_003C);
    idle(5);
    wr(A_TX, 32'h0000_00C3);
    idle(3);
    wr(A_BD, 32'd5);
    idle(85);
    wr(A_BD, 32'd0);
    peek("bauddiv_zero", A_BD, 32'h0000_0001);

    // reset mid-DATA with bytes queued
    wr(A_BD, 32'd4);
    wr(A_TX, 32'h0000_005A);
    wr(A_TX, 32'h0000_0011);
    wr(A_TX, 32'h0000_0022);
    idle(12);
    cyc(1'b1, 1'b0, A_ST, 32'd0);
    peek("midreset_status", A_ST, 32'h0000_0004);
    check("midreset_txd", {31'b0, txd}, 32'd1);
    idle(60);

    // store while full on the same edge as a pop
    wr(A_BD, 32'd2);
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h0000_0080 + 32'(i));
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (m_active && m_t == 10 * m_div - 1 && exp_q.size() == DEPTH) found = 1;
      else idle(1);
    end
    check("full_pop_sync", 32'(found), 32'd1);
    wr(A_TX, 32'h0000_00EE);
    peek("full_pop_status", A_ST, 32'h0000_0039);
    idle(100);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0: ra = A_TX; 1: ra = A_ST; 2: ra = A_BD;
        3: ra = A_OUT; 4: ra = BASE + 32'd12; default: ra = BASE - 32'd4;
      endcase
      ra = ra + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) cyc(1'b1, 1'b0, ra, 32'd0);
      else if (op <= 3) wr(A_TX + 32'($urandom_range(0, 3)), $urandom);
      else if (op == 4) wr(A_ST, $urandom);
      else if (op == 5) wr(A_BD, {$urandom_range(0, 65535), 16'($urandom_range(0, 3))});
      else if (op == 6) wr(ra, $urandom);
      else cyc(1'b0, 1'b0, ra, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
